cv32e40p_id_stim_gen: RTL

Constrained instruction stimulus generator for standalone simulation and formal runs of the CV32E40P ID stage. It sits on the IF→ID side of the decoder and presents legal RV32I/RV32C encodings over a valid/ready handshake. Instructions are selected so the ID-stage operand-mux select paths (register, immediate, JALR target, compressed) are all exercised. Field contents come from an internal LFSR, so runs are reproducible from a seed.

---
 rtl/cv32e40p_id_stim_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cv32e40p_id_stim_gen.sv
// Constrained RV32I/RV32C instruction source for driving the CV32E40P ID stage standalone.
// An LFSR supplies field contents; a valid/ready handshake advances the stream.
module cv32e40p_id_stim_gen #(
    parameter logic [31:0] SEED          = 32'h0000_0001,
    parameter int unsigned N_INSTR       = 256,
    parameter bit          COMPRESSED_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  mode_i,
    input  logic [2:0]  class_i,
    input  logic        id_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic        is_compressed_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] issued_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [31:0] SEED_EFF    = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [15:0] N_LIM       = 16'(N_INSTR);
    localparam logic [1:0]  MODE_RANDOM = 2'b00;
    localparam logic [1:0]  MODE_SWEEP  = 2'b10;
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_lfsr;
    logic [15:0] r_cnt;
    logic [2:0]  r_cls;
    logic [1:0]  r_mode;
    logic        w_run;
    logic        w_start;
    logic        w_xfer;
    logic        w_last;
    logic [2:0]  w_cls_raw;
    logic [2:0]  w_cls;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // funct3 tables below fold L[14:12] onto the legal set (index mod N)
    function automatic logic [2:0] f3_opimm(input logic [2:0] s);
        case (s)
            3'd0, 3'd6: return 3'b000;
            3'd1, 3'd7: return 3'b010;
            3'd2:       return 3'b011;
            3'd3:       return 3'b100;
            3'd4:       return 3'b110;
            default:    return 3'b111;
        endcase
    endfunction

    function automatic logic [2:0] f3_load(input logic [2:0] s);
        case (s)
            3'd0, 3'd5: return 3'b000;
            3'd1, 3'd6: return 3'b001;
            3'd2, 3'd7: return 3'b010;
            3'd3:       return 3'b100;
            default:    return 3'b101;
        endcase
    endfunction

    function automatic logic [2:0] f3_store(input logic [2:0] s);
        case (s)
            3'd0, 3'd3, 3'd6: return 3'b000;
            3'd1, 3'd4, 3'd7: return 3'b001;
            default:          return 3'b010;
        endcase
    endfunction

    function automatic logic [2:0] f3_branch(input logic [2:0] s);
        case (s)
            3'd0, 3'd6: return 3'b000;
            3'd1, 3'd7: return 3'b001;
            3'd2:       return 3'b100;
            3'd3:       return 3'b101;
            3'd4:       return 3'b110;
            default:    return 3'b111;
        endcase
    endfunction

    function automatic logic [31:0] encode(input logic [31:0] l, input logic [2:0] cls);
        logic [4:0] rd_c;
        logic [4:0] imm_c;
        // C.ADDI with rd=0 or imm=0 is a hint/reserved encoding, so force both non-zero
        rd_c  = (l[11:7] == 5'd0) ? 5'd1 : l[11:7];
        imm_c = ({l[12], l[6:2]} == 6'd0) ? 5'd1 : l[6:2];
        case (cls)
            3'd0:    return {7'b0, l[24:15], l[14:12], l[11:7], 7'h33};
            3'd1:    return {l[31:15], f3_opimm(l[14:12]), l[11:7], 7'h13};
            3'd2:    return {l[31:15], 3'b000, l[11:7], 7'h67};
            3'd3:    return {l[31:15], f3_load(l[14:12]), l[11:7], 7'h03};
            3'd4:    return {l[31:15], f3_store(l[14:12]), l[11:7], 7'h23};
            3'd5:    return {l[31:15], f3_branch(l[14:12]), l[11:7], 7'h63};
            3'd6:    return {16'h0, 3'b000, l[12], rd_c, imm_c, 2'b01};
            default: return {l[31:7], 7'h37};
        endcase
    endfunction

    assign w_run   = (r_state == S_RUN);
    assign w_start = start_i && !w_run;
    assign w_xfer  = w_run && id_ready_i;
    assign w_last  = w_xfer && (N_INSTR != 0) && ((r_cnt + 16'd1) == N_LIM);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  if (start_i) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_lfsr  <= SEED_EFF;
            r_cnt   <= 16'd0;
            r_cls   <= 3'd0;
            r_mode  <= MODE_RANDOM;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_cnt  <= 16'd0;
                r_mode <= mode_i;
                r_cls  <= class_i;
            end else if (w_xfer) begin
                r_cnt  <= r_cnt + 16'd1;
                r_lfsr <= lfsr_step(r_lfsr);
                if (r_mode == MODE_SWEEP) r_cls <= r_cls + 3'd1;
            end
        end
    end

    // Fixed mode (01 and 11) and sweep both read the class register
    assign w_cls_raw = (r_mode == MODE_RANDOM) ? r_lfsr[31:29] : r_cls;
    assign w_cls     = (!COMPRESSED_EN && (w_cls_raw == 3'd6)) ? 3'd0 : w_cls_raw;

    assign instr_valid_o   = w_run;
    assign instr_rdata_o   = w_run ? encode(r_lfsr, w_cls) : 32'h0;
    assign is_compressed_o = w_run && (w_cls == 3'd6);
    assign busy_o          = w_run;
    assign done_o          = (r_state == S_DONE);
    assign issued_cnt_o    = r_cnt;

endmodule
